// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU issue controller.
// Op codes, RV32I opcode/funct fields, FSM and decode bundles.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SRL = 4'b1101;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRA = 4'b1111;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [6:0] F7_00 = 7'b0000000;
  localparam logic [6:0] F7_20 = 7'b0100000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    BR_EQ,
    BR_NE,
    BR_LT,
    BR_GE
  } br_kind_e;

  typedef struct packed {
    logic [3:0] op;
    logic       use_imm;
    logic       is_shift_imm;
    logic       is_branch;
    br_kind_e   br;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// RV32I R/I/B instruction word to ALU op and operand-select decode.
// Purely combinational; anything outside the supported subset is illegal.
module alu_issue_ctrl_decode
  import alu_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_00;
  logic       f7_20;
  logic       unused_bits;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign f7_00 = (f7 == F7_00);
  assign f7_20 = (f7 == F7_20);
  assign unused_bits = ^{inst[24:15], inst[11:7]};

  always_comb begin
    dec = '0;
    dec.illegal = 1'b1;
    unique case (1'b1)
      (opc == OPC_R): begin
        unique case (f3)
          3'b000: begin
            dec.op      = f7_20 ? OP_SUB : OP_ADD;
            dec.illegal = !(f7_00 || f7_20);
          end
          3'b001: begin dec.op = OP_SLL; dec.illegal = !f7_00; end
          3'b010: begin dec.op = OP_SLT; dec.illegal = !f7_00; end
          3'b100: begin dec.op = OP_XOR; dec.illegal = !f7_00; end
          3'b101: begin
            dec.op      = f7_20 ? OP_SRA : OP_SRL;
            dec.illegal = !(f7_00 || f7_20);
          end
          3'b110: begin dec.op = OP_OR;  dec.illegal = !f7_00; end
          3'b111: begin dec.op = OP_AND; dec.illegal = !f7_00; end
          default: dec.illegal = 1'b1;
        endcase
      end
      (opc == OPC_I): begin
        dec.use_imm = 1'b1;
        unique case (f3)
          3'b000: begin dec.op = OP_ADD; dec.illegal = 1'b0; end
          3'b010: begin dec.op = OP_SLT; dec.illegal = 1'b0; end
          3'b100: begin dec.op = OP_XOR; dec.illegal = 1'b0; end
          3'b110: begin dec.op = OP_OR;  dec.illegal = 1'b0; end
          3'b111: begin dec.op = OP_AND; dec.illegal = 1'b0; end
          3'b001: begin
            dec.op           = OP_SLL;
            dec.is_shift_imm = 1'b1;
            dec.illegal      = !f7_00;
          end
          3'b101: begin
            dec.op           = f7_20 ? OP_SRA : OP_SRL;
            dec.is_shift_imm = 1'b1;
            dec.illegal      = !(f7_00 || f7_20);
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      (opc == OPC_B): begin
        dec.is_branch = 1'b1;
        unique case (f3)
          3'b000: begin
            dec.op = OP_SUB; dec.br = BR_EQ; dec.illegal = 1'b0;
          end
          3'b001: begin
            dec.op = OP_SUB; dec.br = BR_NE; dec.illegal = 1'b0;
          end
          3'b100: begin
            dec.op = OP_SLT; dec.br = BR_LT; dec.illegal = 1'b0;
          end
          3'b101: begin
            dec.op = OP_SLT; dec.br = BR_GE; dec.illegal = 1'b0;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue side of the external ALU: accept, decode, drive operands,
// capture result, resolve branch, hand result to writeback.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int                XLEN    = 32,
  parameter logic [XLEN-1:0]   ERR_RES = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_res,
  input  logic            alu_zero,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic            out_taken,
  output logic            out_err
);

  dec_t            dec;
  state_e          state_q;
  logic [XLEN-1:0] alu_a_q;
  logic [XLEN-1:0] alu_b_q;
  logic [3:0]      alu_op_q;
  logic            is_br_q;
  br_kind_e        br_q;
  logic [XLEN-1:0] out_res_q;
  logic            out_taken_q;
  logic            out_err_q;
  logic            out_valid_q;
  logic [XLEN-1:0] b_d;
  logic            taken_d;

  alu_issue_ctrl_decode u_dec (
    .inst (inst),
    .dec  (dec)
  );

  always_comb begin
    b_d = rs2_data;
    if (dec.is_shift_imm)
      b_d = {{(XLEN-5){1'b0}}, inst[24:20]};
    else if (dec.use_imm)
      b_d = {{(XLEN-12){inst[31]}}, inst[31:20]};
  end

  always_comb begin
    taken_d = 1'b0;
    if (is_br_q) begin
      unique case (br_q)
        BR_EQ: taken_d = alu_zero;
        BR_NE: taken_d = !alu_zero;
        BR_LT: taken_d = alu_res[0];
        BR_GE: taken_d = !alu_res[0];
        default: taken_d = 1'b0;
      endcase
    end
  end

  // out_valid rises one edge after entering DONE, so results settle first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_AND;
      is_br_q     <= 1'b0;
      br_q        <= BR_EQ;
      out_res_q   <= '0;
      out_taken_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            if (dec.illegal) begin
              out_res_q   <= ERR_RES;
              out_taken_q <= 1'b0;
              out_err_q   <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              alu_a_q  <= rs1_data;
              alu_b_q  <= b_d;
              alu_op_q <= dec.op;
              is_br_q  <= dec.is_branch;
              br_q     <= dec.br;
              state_q  <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          out_res_q   <= alu_res;
          out_taken_q <= taken_d;
          out_err_q   <= 1'b0;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign out_res   = out_res_q;
  assign out_taken = out_taken_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU
// sharing the op-code table.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_res;
  logic        out_taken;
  logic        out_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inst      (inst),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_taken (out_taken),
    .out_err   (out_err)
  );

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'b0000: alu_res = alu_a & alu_b;
      4'b0001: alu_res = alu_a | alu_b;
      4'b0010: alu_res = alu_a + alu_b;
      4'b0110: alu_res = alu_a - alu_b;
      4'b0111: alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b0100: alu_res = ~(alu_a | alu_b);
      4'b1100: alu_res = alu_a ^ alu_b;
      4'b1101: alu_res = alu_a >> alu_b[4:0];
      4'b1110: alu_res = alu_a << alu_b[4:0];
      4'b1111: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_res = '0;
    endcase
  end
  assign alu_zero = (alu_res == '0);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] a,
                      input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("send_rdy", {31'b0, in_ready}, 32'd1);
    inst = i; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    inst = $urandom; rs1_data = $urandom; rs2_data = $urandom;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_hs(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_vld0"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_rdy1"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] i,
                     input logic [31:0] a, input logic [31:0] b,
                     input int lat_e, input logic [31:0] res_e,
                     input logic tk_e, input logic err_e,
                     input logic [3:0] op_e, input logic [31:0] a_e,
                     input logic [31:0] b_e);
    int lat;
    send(i, a, b);
    wait_out(lat);
    chk({tag, "_lat"}, lat, lat_e);
    chk({tag, "_res"}, out_res, res_e);
    chk({tag, "_tk"}, {31'b0, out_taken}, {31'b0, tk_e});
    chk({tag, "_err"}, {31'b0, out_err}, {31'b0, err_e});
    chk({tag, "_op"}, {28'b0, alu_op}, {28'b0, op_e});
    chk({tag, "_a"}, alu_a, a_e);
    chk({tag, "_b"}, alu_b, b_e);
    finish_hs(tag);
  endtask

  initial begin
    int lat;
    logic [31:0] hold;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_op", {28'b0, alu_op}, 32'd0);
    chk("rst_a", alu_a, 32'd0);
    chk("rst_res", out_res, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", {31'b0, in_ready}, 32'd1);

    run("add", 32'h0020_8033, 5, 7, 2, 12, 0, 0, 4'b0010, 5, 7);
    run("sub", 32'h4020_8033, 5, 7, 2, 32'hFFFF_FFFE, 0, 0,
        4'b0110, 5, 7);
    run("xor", 32'h0020_C033, 32'hF0F0, 32'hFF00, 2, 32'h0FF0, 0, 0,
        4'b1100, 32'hF0F0, 32'hFF00);
    run("or", 32'h0020_E033, 32'hF0, 32'h0F, 2, 32'hFF, 0, 0,
        4'b0001, 32'hF0, 32'h0F);
    run("sll", 32'h0020_9033, 1, 31, 2, 32'h8000_0000, 0, 0,
        4'b1110, 1, 31);
    run("beq_t", 32'h0020_8063, 32'h1234, 32'h1234, 2, 0, 1, 0,
        4'b0110, 32'h1234, 32'h1234);
    run("beq_n", 32'h0020_8063, 32'h1234, 32'h1235, 2, 32'hFFFF_FFFF,
        0, 0, 4'b0110, 32'h1234, 32'h1235);
    run("bne_n", 32'h0020_9063, 32'h1234, 32'h1234, 2, 0, 0, 0,
        4'b0110, 32'h1234, 32'h1234);
    run("bne_t", 32'h0020_9063, 32'h1234, 32'h1235, 2, 32'hFFFF_FFFF,
        1, 0, 4'b0110, 32'h1234, 32'h1235);
    run("blt", 32'h0020_C063, 32'hFFFF_FFFF, 1, 2, 1, 1, 0,
        4'b0111, 32'hFFFF_FFFF, 1);
    run("bge", 32'h0020_D063, 32'hFFFF_FFFF, 1, 2, 1, 0, 0,
        4'b0111, 32'hFFFF_FFFF, 1);
    run("srai", 32'h4040_D013, 32'h8000_0000, 32'h99, 2,
        32'hF800_0000, 0, 0, 4'b1111, 32'h8000_0000, 4);
    run("slti", 32'h0000_A013, 32'hFFFF_FFFF, 32'h55, 2, 1, 0, 0,
        4'b0111, 32'hFFFF_FFFF, 0);
    run("addi", 32'hFFF0_8013, 10, 32'h55, 2, 9, 0, 0,
        4'b0010, 10, 32'hFFFF_FFFF);
    run("sltu", 32'h0020_B033, 3, 4, 1, 0, 0, 1,
        4'b0010, 10, 32'hFFFF_FFFF);
    run("lui", 32'h1234_5037, 3, 4, 1, 0, 0, 1,
        4'b0010, 10, 32'hFFFF_FFFF);
    run("and_f7", 32'h4020_F033, 3, 4, 1, 0, 0, 1,
        4'b0010, 10, 32'hFFFF_FFFF);
    run("add2", 32'h0020_8033, 100, 23, 2, 123, 0, 0,
        4'b0010, 100, 23);

    send(32'h0020_8033, 40, 2);
    wait_out(lat);
    chk("bp_lat", lat, 2);
    hold = out_res;
    chk("bp_res", hold, 42);
    inst = 32'h4020_8033; rs1_data = 5; rs2_data = 7; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_hold", out_res, 42);
      chk("bp_vld", {31'b0, out_valid}, 32'd1);
      chk("bp_rdy", {31'b0, in_ready}, 32'd0);
      chk("bp_op", {28'b0, alu_op}, 32'h2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_vld", {31'b0, out_valid}, 32'd0);
    chk("bp_rel_rdy", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_acc_rdy", {31'b0, in_ready}, 32'd0);
    wait_out(lat);
    chk("bp2_lat", lat, 2);
    chk("bp2_res", out_res, 32'hFFFF_FFFE);
    chk("bp2_op", {28'b0, alu_op}, 32'h6);
    finish_hs("bp2");

    send(32'h0020_8033, 9, 9);
    rst_n = 1'b0;
    #1;
    chk("mrst_a", alu_a, 0);
    chk("mrst_b", alu_b, 0);
    chk("mrst_op", {28'b0, alu_op}, 0);
    chk("mrst_vld", {31'b0, out_valid}, 0);
    chk("mrst_res", out_res, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("post_vld", {31'b0, out_valid}, 0);
      chk("post_rdy", {31'b0, in_ready}, 1);
    end
    run("post_add", 32'h0020_8033, 1, 2, 2, 3, 0, 0, 4'b0010, 1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
